// File: rtl/dmem_ctrl.sv
// RV32I data-memory controller: valid/ready request channel, one-cycle ACCESS
// into a byte-laned word array, registered read, load extension and fault flags.
module dmem_ctrl #(
    parameter int ADDR_W       = 8,
    parameter bit ERR_ON_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [2:0]  func3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        err_reg;

    logic             misaligned, illegal, out_of_range, access_err;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       byte_en;
    logic [31:0]      wr_word;
    logic [31:0]      rd_word;
    logic             wr_en, rd_en;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;

    assign word_idx = addr_reg[ADDR_W-1:2];

    // Faults are judged on the captured request during ACCESS.
    always_comb begin
        misaligned   = (func3_reg[1:0] == 2'b01 && addr_reg[0]) ||
                       (func3_reg[1:0] == 2'b10 && addr_reg[1:0] != 2'b00);
        illegal      = we_reg ? (func3_reg[2] || func3_reg[1:0] == 2'b11)
                              : (func3_reg == 3'b011 || func3_reg[2:1] == 2'b11);
        out_of_range = ERR_ON_RANGE && (addr_reg[31:ADDR_W] != '0);
        access_err   = misaligned || illegal || out_of_range;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            func3_reg <= 3'b000;
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req_valid) begin
                we_reg    <= req_we;
                func3_reg <= req_func3;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            if (state_reg == ACCESS)
                err_reg <= access_err;
        end
    end

    // Store data is replicated across lanes so each lane just picks its own byte.
    always_comb begin
        byte_en = 4'b0000;
        wr_word = wdata_reg;
        case (func3_reg[1:0])
            2'b00: begin
                byte_en = 4'b0001 << addr_reg[1:0];
                wr_word = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                byte_en = addr_reg[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_reg[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    assign wr_en = (state_reg == ACCESS) && we_reg && !access_err;
    assign rd_en = (state_reg == ACCESS) && !we_reg && !access_err;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (wr_en && byte_en[gi])
                    mem[word_idx] <= wr_word[8*gi +: 8];
                if (rd_en)
                    rd_byte_reg <= mem[word_idx];
            end

            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    // Extension works from registered state only, so the response holds steady while stalled.
    always_comb begin
        lane_byte = rd_word[{addr_reg[1:0], 3'b000} +: 8];
        lane_half = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
        rsp_rdata = 32'h0;
        if (state_reg == RESP && !err_reg && !we_reg) begin
            case (func3_reg)
                3'b000:  rsp_rdata = {{24{lane_byte[7]}}, lane_byte};
                3'b100:  rsp_rdata = {24'h0, lane_byte};
                3'b001:  rsp_rdata = {{16{lane_half[15]}}, lane_half};
                3'b101:  rsp_rdata = {16'h0, lane_half};
                3'b010:  rsp_rdata = rd_word;
                default: rsp_rdata = 32'h0;
            endcase
        end
    end

    assign rsp_err = (state_reg == RESP) && err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios then random loads/stores, checked
// against a byte-array reference model of the RV32I access rules.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;
    byte unsigned ref_mem [256];

    dmem_ctrl #(.ADDR_W(8), .ERR_ON_RANGE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Access of 2**func3[1:0] bytes; must be naturally aligned, legal and below 256.
    function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output bit err, output logic [31:0] rd);
        int  nb;
        bit  illegal;
        nb      = 1 << f3[1:0];
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        err     = illegal || (a % nb != 0) || (a >= 32'd256);
        rd      = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_mem[a + i];
                if (!f3[2] && nb < 4 && rd[8*nb-1])
                    rd = rd | ~((32'h1 << (8*nb)) - 32'h1);
            end
        end
    endfunction

    task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int stall, input string tag);
        bit          e_err;
        logic [31:0] e_rd;
        int          t;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
        rsp_ready = 1'b0;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check({tag, "_ready_timeout"}, 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        model(we, f3, a, wd, e_err, e_rd);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_access_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_access_ready"}, 32'(req_ready), 32'h0);
        @(negedge clk);
        check({tag, "_resp_valid"}, 32'(rsp_valid), 32'h1);
        check({tag, "_resp_err"}, 32'(rsp_err), 32'(e_err));
        check({tag, "_resp_rdata"}, rsp_rdata, e_rd);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, 32'(rsp_valid), 32'h1);
            check({tag, "_stall_rdata"}, rsp_rdata, e_rd);
            check({tag, "_stall_err"}, 32'(rsp_err), 32'(e_err));
            check({tag, "_stall_ready"}, 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_post_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_post_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_post_ready"}, 32'(req_ready), 32'h1);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        $display("xact %s we=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d",
                 tag, we, f3, a, wd, e_rd, e_err);
    endtask

    initial begin
        logic [31:0] ra, rw;
        bit          rwe;
        logic [2:0]  rf3;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", 32'(rsp_err), 32'h0);
        reset_n = 1'b1;

        for (int w = 0; w < 64; w++)
            xact(1'b1, 3'b010, 32'(w * 4), (w == 2) ? 32'h11223344 : $urandom, 0, "init_sw");

        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw_10");
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_10");
        xact(1'b1, 3'b000, 32'h13, 32'h80, 0, "sb_13");
        xact(1'b0, 3'b000, 32'h13, 32'h0, 0, "lb_13");
        xact(1'b0, 3'b100, 32'h13, 32'h0, 0, "lbu_13");
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_10b");
        xact(1'b1, 3'b001, 32'h22, 32'h1234, 0, "sh_22");
        xact(1'b0, 3'b001, 32'h22, 32'h0, 0, "lh_22");
        xact(1'b0, 3'b101, 32'h20, 32'h0, 0, "lhu_20");
        xact(1'b0, 3'b010, 32'h11, 32'h0, 0, "lw_mis");
        xact(1'b1, 3'b001, 32'h23, 32'hFFFF, 0, "sh_mis");
        xact(1'b0, 3'b010, 32'h100, 32'h0, 0, "lw_range");
        xact(1'b1, 3'b010, 32'h104, 32'hFFFFFFFF, 0, "sw_range");
        xact(1'b0, 3'b010, 32'h20, 32'h0, 0, "lw_20");
        xact(1'b0, 3'b010, 32'h04, 32'h0, 0, "lw_04");
        xact(1'b0, 3'b010, 32'h10, 32'h0, 5, "lw_stall");

        // Reset dropped while the store sits in ACCESS: no write, no response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010;
        req_addr = 32'h08; req_wdata = 32'h55;
        check("rstmid_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rstmid_ready_now", 32'(req_ready), 32'h1);
        check("rstmid_valid_now", 32'(rsp_valid), 32'h0);
        check("rstmid_rdata_now", rsp_rdata, 32'h0);
        check("rstmid_err_now", 32'(rsp_err), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rstmid_no_rsp", 32'(rsp_valid), 32'h0);
        end
        xact(1'b0, 3'b010, 32'h08, 32'h0, 0, "lw_08_after_rst");

        for (int n = 0; n < 300; n++) begin
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            rw  = $urandom;
            xact(rwe, rf3, ra, rw, $urandom_range(0, 3), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
